// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, load and cascade.
// All state bits update on the same rising edge; no ripple between stages.
module sync_updown_counter #(
    parameter int     WIDTH       = 3,
    parameter longint MODULUS     = 8,
    parameter int     SATURATE    = 0,
    parameter int     RESET_VALUE = 0
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             input_enable,
    input  logic             input_up_down,
    input  logic             input_load,
    input  logic [WIDTH-1:0] input_load_value,
    output logic [WIDTH-1:0] output_count,
    output logic             output_terminal,
    output logic             output_wrap,
    output logic             output_saturated
);

    // Bad parameter sets are rejected while elaborating.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sync_updown_counter: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
            $error("sync_updown_counter: MODULUS must be 2..2**WIDTH");
        end
        if (RESET_VALUE < 0 || longint'(RESET_VALUE) >= MODULUS) begin : g_bad_rst
            $error("sync_updown_counter: RESET_VALUE must be below MODULUS");
        end
    endgenerate

    // Range limits carried in WIDTH+1 bits so MODULUS = 2**WIDTH fits.
    localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_W = MOD_W - ONE_W;
    localparam logic [WIDTH-1:0] MAX   = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST   = WIDTH'(RESET_VALUE);
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             saturated;

    logic [WIDTH:0]   count_w;
    logic [WIDTH:0]   load_w;
    logic [WIDTH:0]   step_w;
    logic [WIDTH-1:0] load_fit;
    logic [WIDTH-1:0] wrap_to;
    logic             at_top;
    logic             at_bot;
    logic             bound;

    assign count_w  = {1'b0, count};
    assign load_w   = {1'b0, input_load_value};
    assign at_top   = (count_w == MAX_W);
    assign at_bot   = (count == '0);
    assign bound    = input_up_down ? at_top : at_bot;

    // Step is only used away from the bounds, so it never leaves the range.
    assign step_w   = input_up_down ? count_w + ONE_W : count_w - ONE_W;

    // Out-of-range load values clamp to the top of the range.
    assign load_fit = (load_w < MOD_W) ? input_load_value : MAX;
    assign wrap_to  = input_up_down ? '0 : MAX;

    // Cascade flag: the next enabled step in this direction hits a bound.
    assign output_terminal = input_enable & bound;

    // Count register with reset > load > count > hold priority.
    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            count     <= RST;
            wrap      <= 1'b0;
            saturated <= 1'b0;
        end else if (input_load) begin
            count     <= load_fit;
            wrap      <= 1'b0;
            saturated <= 1'b0;
        end else if (input_enable) begin
            if (!bound) begin
                count     <= step_w[WIDTH-1:0];
                wrap      <= 1'b0;
                saturated <= 1'b0;
            end else if (SAT) begin
                wrap      <= 1'b0;
                saturated <= 1'b1;
            end else begin
                count     <= wrap_to;
                wrap      <= 1'b1;
                saturated <= 1'b0;
            end
        end else begin
            wrap      <= 1'b0;
            saturated <= 1'b0;
        end
    end

    assign output_count     = count;
    assign output_wrap      = wrap;
    assign output_saturated = saturated;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: three configurations share one stimulus,
// checked every cycle against an arithmetic model, plus a two-stage cascade.
module tb_sync_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, ld;
    logic [2:0] lv;

    logic [2:0] cnt [3];
    logic       term [3];
    logic       wrp [3];
    logic       sat [3];

    logic       c_rst, c_en;
    logic [2:0] lo_cnt, hi_cnt;
    logic       lo_term, hi_term;
    logic       lo_wrap, hi_wrap, lo_sat, hi_sat;

    int n_tests = 0;
    int n_fail  = 0;

    // model state per instance: 0 = M8 wrap, 1 = M6 wrap, 2 = M8 saturate
    int mods [3] = '{8, 6, 8};
    bit sats [3] = '{1'b0, 1'b0, 1'b1};
    int mc [3];
    bit mw [3];
    bit ms [3];
    bit valid = 1'b0;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0)) u_m8 (
        .input_clock1_1(clk), .input_reset1_2(rst), .input_enable(en),
        .input_up_down(up), .input_load(ld), .input_load_value(lv),
        .output_count(cnt[0]), .output_terminal(term[0]),
        .output_wrap(wrp[0]), .output_saturated(sat[0]));

    sync_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .RESET_VALUE(0)) u_m6 (
        .input_clock1_1(clk), .input_reset1_2(rst), .input_enable(en),
        .input_up_down(up), .input_load(ld), .input_load_value(lv),
        .output_count(cnt[1]), .output_terminal(term[1]),
        .output_wrap(wrp[1]), .output_saturated(sat[1]));

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1), .RESET_VALUE(0)) u_sat (
        .input_clock1_1(clk), .input_reset1_2(rst), .input_enable(en),
        .input_up_down(up), .input_load(ld), .input_load_value(lv),
        .output_count(cnt[2]), .output_terminal(term[2]),
        .output_wrap(wrp[2]), .output_saturated(sat[2]));

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0)) u_lo (
        .input_clock1_1(clk), .input_reset1_2(c_rst), .input_enable(c_en),
        .input_up_down(1'b1), .input_load(1'b0), .input_load_value(3'd0),
        .output_count(lo_cnt), .output_terminal(lo_term),
        .output_wrap(lo_wrap), .output_saturated(lo_sat));

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .RESET_VALUE(0)) u_hi (
        .input_clock1_1(clk), .input_reset1_2(c_rst), .input_enable(lo_term),
        .input_up_down(1'b1), .input_load(1'b0), .input_load_value(3'd0),
        .output_count(hi_cnt), .output_terminal(hi_term),
        .output_wrap(hi_wrap), .output_saturated(hi_sat));

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: range arithmetic on plain ints, advanced on each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit edge_hit;
            if (rst) begin
                mc[i] = 0; mw[i] = 0; ms[i] = 0;
            end else if (ld) begin
                mc[i] = (int'(lv) < mods[i]) ? int'(lv) : mods[i] - 1;
                mw[i] = 0; ms[i] = 0;
            end else if (en) begin
                edge_hit = up ? (mc[i] == mods[i] - 1) : (mc[i] == 0);
                if (edge_hit && sats[i]) begin
                    ms[i] = 1; mw[i] = 0;
                end else begin
                    mc[i] = up ? (mc[i] + 1) % mods[i]
                               : (mc[i] + mods[i] - 1) % mods[i];
                    mw[i] = edge_hit; ms[i] = 0;
                end
            end else begin
                mw[i] = 0; ms[i] = 0;
            end
        end
        if (rst) valid = 1'b1;
    end

    // Per-cycle comparison, half a period away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            for (int i = 0; i < 3; i++) begin
                bit t_exp;
                t_exp = en && (up ? (mc[i] == mods[i] - 1) : (mc[i] == 0));
                chk($sformatf("model_count[%0d]", i), cnt[i], mc[i]);
                chk($sformatf("model_wrap[%0d]", i), wrp[i], mw[i]);
                chk($sformatf("model_sat[%0d]", i), sat[i], ms[i]);
                chk($sformatf("model_term[%0d]", i), term[i], t_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; en = 0; up = 1; ld = 0; lv = 0;
        c_rst = 1; c_en = 0;
        cyc();
        chk("reset_count", cnt[0], 0);
        chk("reset_wrap", wrp[0], 0);
        chk("reset_sat", sat[2], 0);

        // 1: M8 counts up through the wrap
        rst = 0; en = 1; up = 1;
        for (int k = 1; k <= 9; k++) begin
            #1;
            chk("t1_term", term[0], ((k - 1) % 8 == 7) ? 1 : 0);
            cyc();
            chk("t1_count", cnt[0], k % 8);
            chk("t1_wrap", wrp[0], (k == 8) ? 1 : 0);
        end

        // 2: M6 counts down from 0; saturating M8 blocks at 0
        rst = 1; en = 0;
        cyc();
        rst = 0; en = 1; up = 0;
        cyc();
        chk("t2_count0", cnt[1], 5);
        chk("t2_wrap0", wrp[1], 1);
        chk("t2_sat_hold", cnt[2], 0);
        chk("t2_sat_flag", sat[2], 1);
        chk("t2_model_pin", mc[1], 5);
        cyc();
        chk("t2_count1", cnt[1], 4);
        chk("t2_wrap1", wrp[1], 0);
        cyc();
        chk("t2_count2", cnt[1], 3);

        // 3: saturating M8 held at the top
        en = 0; ld = 1; lv = 6;
        cyc();
        chk("t3_load", cnt[2], 6);
        ld = 0; en = 1; up = 1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("t3_count", cnt[2], 7);
            chk("t3_sat", sat[2], (k > 1) ? 1 : 0);
            chk("t3_wrap", wrp[2], 0);
        end
        up = 0;
        cyc();
        chk("t3_down", cnt[2], 6);
        chk("t3_sat_clr", sat[2], 0);

        // idle hold clears flags
        en = 0;
        cyc();
        chk("idle_hold", cnt[2], 6);

        // 4: load clamp beats enable, then wrap from the clamp value
        ld = 1; lv = 7; en = 1; up = 1;
        cyc();
        chk("t4_clamp", cnt[1], 5);
        chk("t4_noclamp_m8", cnt[0], 7);
        ld = 0;
        cyc();
        chk("t4_wrap_count", cnt[1], 0);
        chk("t4_wrap", wrp[1], 1);

        // 5: reset wins over a simultaneous load mid-count
        rst = 1; ld = 0;
        cyc();
        rst = 0; en = 1; up = 1;
        repeat (4) cyc();
        chk("t5_pre", cnt[0], 4);
        rst = 1; ld = 1; lv = 2;
        cyc();
        chk("t5_count", cnt[0], 0);
        chk("t5_wrap", wrp[0], 0);
        chk("t5_sat", sat[2], 0);
        rst = 0; ld = 0; en = 0;
        cyc();

        // 6: two-stage cascade, 64 up edges
        c_rst = 1;
        cyc();
        chk("t6_reset", {29'd0, hi_cnt, lo_cnt}, 0);
        c_rst = 0; c_en = 1;
        for (int e = 1; e <= 64; e++) begin
            cyc();
            chk("t6_lo", lo_cnt, e % 8);
            chk("t6_hi", hi_cnt, (e / 8) % 8);
        end
        chk("t6_final", {29'd0, hi_cnt, lo_cnt}, 0);
        c_en = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
